// File: rtl/jgate_pkg.sv
// rtl/jgate_pkg.sv - shared operation encodings for the jgate unit
//
// Purpose : Holds the 2-bit operation select type used by the registered
//           path of jgate_unit and by every jgate_slice instance.
// Contents: jgate_op_e  - OP_AND / OP_OR / OP_NOT / OP_NAND
//           JGATE_DEFAULT_WIDTH - default operand width
package jgate_pkg;

   localparam int JGATE_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_NOT  = 2'b10,   // NOT of operand a only; b is ignored
      OP_NAND = 2'b11
   } jgate_op_e;

endpackage

// File: rtl/jgate_slice.sv
// rtl/jgate_slice.sv - one-bit gate slice with operation select
//
// Purpose : Computes AND, OR and NOT for a single bit position and selects
//           one of AND / OR / NOT / NAND for the registered path.
// Ports   : i_a, i_b - operand bits
//           i_op     - operation select (jgate_op_e)
//           o_and    - i_a & i_b
//           o_or     - i_a | i_b
//           o_not    - ~i_a
//           o_sel    - result chosen by i_op
module jgate_slice
   import jgate_pkg::*;
(
   input  logic      i_a,
   input  logic      i_b,
   input  jgate_op_e i_op,
   output logic      o_and,
   output logic      o_or,
   output logic      o_not,
   output logic      o_sel
);

   logic w_and;
   logic w_or;
   logic w_not;
   logic w_nand;

   and g_and  (w_and,  i_a, i_b);
   or  g_or   (w_or,   i_a, i_b);
   not g_not  (w_not,  i_a);
   // NAND reuses the AND gate output rather than a separate NAND primitive.
   not g_nand (w_nand, w_and);

   assign o_and = w_and;
   assign o_or  = w_or;
   assign o_not = w_not;

   always_comb begin
      o_sel = w_and;
      case (i_op)
         OP_AND:  o_sel = w_and;
         OP_OR:   o_sel = w_or;
         OP_NOT:  o_sel = w_not;
         OP_NAND: o_sel = w_nand;
         default: o_sel = w_and;
      endcase
   end

endmodule

// File: rtl/jgate_unit.sv
// rtl/jgate_unit.sv - bitwise gate unit with combinational and registered outputs
//
// Purpose : Bitwise AND / OR / NOT of two WIDTH-bit operands presented
//           combinationally, plus a one-cycle registered result of the
//           operation chosen by op, captured when valid_in is high.
// Ports   : clk      - rising-edge clock
//           reset    - synchronous, active-high; clears y_q and valid_q only
//           a, b     - operands (b unused by NOT)
//           op       - registered-path select (jgate_op_e encoding)
//           valid_in - capture enable for the registered path
//           and_y    - a & b   (combinational)
//           or_y     - a | b   (combinational)
//           not_y    - ~a      (combinational)
//           y_q      - registered selected result
//           valid_q  - high when y_q was loaded on the previous edge
module jgate_unit
   import jgate_pkg::*;
#(
   parameter int WIDTH = JGATE_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             valid_in,
   output logic [WIDTH-1:0] and_y,
   output logic [WIDTH-1:0] or_y,
   output logic [WIDTH-1:0] not_y,
   output logic [WIDTH-1:0] y_q,
   output logic             valid_q
);

   jgate_op_e        w_op;
   logic [WIDTH-1:0] w_and;
   logic [WIDTH-1:0] w_or;
   logic [WIDTH-1:0] w_not;
   logic [WIDTH-1:0] w_sel;

   // Declaration initialisers give the power-up state ahead of any reset.
   logic [WIDTH-1:0] r_y_q     = '0;
   logic             r_valid_q = 1'b0;

   assign w_op = jgate_op_e'(op);

   // Each slice sees only its own bit position, so no cross-bit paths exist.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
      jgate_slice u_slice (
         .i_a   (a[gi]),
         .i_b   (b[gi]),
         .i_op  (w_op),
         .o_and (w_and[gi]),
         .o_or  (w_or[gi]),
         .o_not (w_not[gi]),
         .o_sel (w_sel[gi])
      );
   end

   assign and_y = w_and;
   assign or_y  = w_or;
   assign not_y = w_not;

   // Reset has priority over a simultaneous capture; valid_q mirrors the
   // previous edge's valid_in while y_q holds across idle edges.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_y_q     <= '0;
         r_valid_q <= 1'b0;
      end else begin
         r_valid_q <= valid_in;
         if (valid_in) begin
            r_y_q <= w_sel;
         end
      end
   end

   assign y_q     = r_y_q;
   assign valid_q = r_valid_q;

endmodule

// File: tb/tb_jgate_unit.sv
// tb/tb_jgate_unit.sv - self-checking bench for jgate_unit
module tb_jgate_unit;

   logic       clk;
   logic       reset;
   logic [7:0] a;
   logic [7:0] b;
   logic [1:0] op;
   logic       valid_in;
   logic [7:0] and_y;
   logic [7:0] or_y;
   logic [7:0] not_y;
   logic [7:0] y_q;
   logic       valid_q;

   int n_tests = 0;
   int n_fail  = 0;

   jgate_unit #(.WIDTH(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .a        (a),
      .b        (b),
      .op       (op),
      .valid_in (valid_in),
      .and_y    (and_y),
      .or_y     (or_y),
      .not_y    (not_y),
      .y_q      (y_q),
      .valid_q  (valid_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       vin;
      logic [1:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] e_and;
      logic [7:0] e_or;
      logic [7:0] e_not;
      logic [7:0] e_y;
      logic       e_v;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
      end
   endtask

   // Drive on the falling edge, check combinational outputs before the
   // rising edge, then check the registered outputs just after it.
   task automatic step(input string tag, input logic rst, input logic vin,
                       input logic [1:0] o, input logic [7:0] va, input logic [7:0] vb,
                       input logic [7:0] e_and, input logic [7:0] e_or,
                       input logic [7:0] e_not, input logic [7:0] e_y, input logic e_v);
      @(negedge clk);
      reset    = rst;
      valid_in = vin;
      op       = o;
      a        = va;
      b        = vb;
      #1;
      chk({tag, "_and"}, and_y, e_and);
      chk({tag, "_or"},  or_y,  e_or);
      chk({tag, "_not"}, not_y, e_not);
      @(posedge clk);
      #1;
      chk({tag, "_yq"}, y_q, e_y);
      chk({tag, "_vq"}, {7'd0, valid_q}, {7'd0, e_v});
   endtask

   initial begin
      reset    = 1'b0;
      valid_in = 1'b0;
      op       = 2'b00;
      a        = 8'h00;
      b        = 8'h00;

      //           rst   vin   op     a      b      and    or     not    y_q    v_q
      vecs.push_back('{1'b1, 1'b0, 2'b00, 8'hF0, 8'h3C, 8'h30, 8'hFC, 8'h0F, 8'h00, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 2'b00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 2'b00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 2'b11, 8'hAA, 8'h0F, 8'h0A, 8'hAF, 8'h55, 8'hF5, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 2'b10, 8'h5A, 8'h00, 8'h00, 8'h5A, 8'hA5, 8'hA5, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 2'b10, 8'h12, 8'h34, 8'h10, 8'h36, 8'hED, 8'hA5, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 2'b00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hA5, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 2'b01, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hA5, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 2'b00, 8'hC3, 8'h81, 8'h81, 8'hC3, 8'h3C, 8'h81, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 2'b01, 8'hC3, 8'h81, 8'h81, 8'hC3, 8'h3C, 8'hC3, 1'b1});
      vecs.push_back('{1'b1, 1'b1, 2'b01, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 2'b01, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 2'b01, 8'h0F, 8'hF0, 8'h00, 8'hFF, 8'hF0, 8'hFF, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 2'b00, 8'h01, 8'h80, 8'h00, 8'h81, 8'hFE, 8'h00, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 2'b11, 8'h01, 8'h80, 8'h00, 8'h81, 8'hFE, 8'hFF, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 2'b10, 8'h96, 8'hFF, 8'h96, 8'hFF, 8'h69, 8'h69, 1'b1});

      // Power-up state before any reset edge has been applied.
      #1;
      chk("pwrup_yq", y_q, 8'h00);
      chk("pwrup_vq", {7'd0, valid_q}, 8'h00);

      foreach (vecs[i]) begin
         step($sformatf("v%0d", i), vecs[i].rst, vecs[i].vin, vecs[i].op,
              vecs[i].a, vecs[i].b, vecs[i].e_and, vecs[i].e_or,
              vecs[i].e_not, vecs[i].e_y, vecs[i].e_v);
      end

      // Reset arriving mid-stream drops the capture on that edge; the first
      // result after release follows the first valid edge with reset low.
      step("ms_load", 1'b0, 1'b1, 2'b00, 8'h3C, 8'hFF, 8'h3C, 8'hFF, 8'hC3, 8'h3C, 1'b1);
      step("ms_rst",  1'b1, 1'b1, 2'b01, 8'hA0, 8'h05, 8'h00, 8'hA5, 8'h5F, 8'h00, 1'b0);
      step("ms_rel",  1'b0, 1'b1, 2'b01, 8'hA0, 8'h05, 8'h00, 8'hA5, 8'h5F, 8'hA5, 1'b1);
      step("ms_idle", 1'b0, 1'b0, 2'b11, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hA5, 1'b0);

      // Combinational outputs follow a and b mid-cycle with no clock edge.
      @(negedge clk);
      a = 8'h6C;
      b = 8'h3A;
      #1;
      chk("mid_and", and_y, 8'h28);
      chk("mid_or",  or_y,  8'h7E);
      chk("mid_not", not_y, 8'h93);
      chk("mid_yq",  y_q,   8'hA5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
